// File: rtl/shift_pkg.sv
// Shared types and constants for the bit-serial shift sequencer.
package shift_pkg;

  localparam int unsigned SHIFT_W = 32;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } shift_seq_state_t;

endpackage

// File: rtl/mux32.sv
// 32:1 single-bit multiplexer: y = a[s].
module mux32 (
  input  logic [31:0] a,
  input  logic [4:0]  s,
  output logic        y
);

  assign y = a[s];

endmodule

// File: rtl/shift_sequencer.sv
// Bit-serial 32-bit shifter: one shared mux32 produces one result bit per cycle.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (enables ROR; otherwise ROR acts as SRL).
module shift_sequencer
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  shift_seq_state_t   state;
  logic [SHIFT_W-1:0] a_q;
  logic [4:0]         shamt_q;
  shift_op_t          op_q;
  logic [4:0]         idx;

  logic [5:0]         sum6;
  logic [4:0]         src;
  logic               y;
  logic               bit_val;

  assign in_ready = (state == IDLE);

  // 6-bit sum so the right-shift range test sees the carry out of bit 4
  assign sum6 = {1'b0, idx} + {1'b0, shamt_q};

  mux32 u_mux (
    .a (a_q),
    .s (src),
    .y (y)
  );

  // Select source index and mask/fill out-of-range bits for the current op
  always_comb begin
    src     = sum6[4:0];
    bit_val = 1'b0;
    case (op_q)
      SHIFT_SLL: begin
        src     = idx - shamt_q;
        bit_val = (idx >= shamt_q) ? y : 1'b0;
      end
      SHIFT_SRA: begin
        src     = sum6[4:0];
        bit_val = sum6[5] ? a_q[31] : y;
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      SHIFT_ROR: begin
        src     = sum6[4:0];
        bit_val = y;
      end
`endif
      default: begin
        src     = sum6[4:0];
        bit_val = sum6[5] ? 1'b0 : y;
      end
    endcase
  end

  // Control FSM with registered handshake outputs and serial result build
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      a_q       <= '0;
      shamt_q   <= '0;
      op_q      <= SHIFT_SLL;
      idx       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            shamt_q <= shamt;
            op_q    <= shift_op_t'(op);
            idx     <= '0;
            result  <= '0;
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          result[idx] <= bit_val;
          idx         <= idx + 5'd1;
          if (idx == 5'd31) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, corner sequences, random model check.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] va, input logic [4:0] vs, input logic [1:0] vo);
    logic [63:0] dbl;
    dbl = {va, va} >> vs;
    case (vo)
      2'b00:   return va << vs;
      2'b01:   return va >> vs;
      2'b10:   return $unsigned($signed(va) >>> vs);
`ifdef SHIFT_SEQ_ROTATE_EN
      default: return dbl[31:0];
`else
      default: return va >> vs;
`endif
    endcase
  endfunction

  task automatic start_req(input logic [31:0] va, input logic [4:0] vs, input logic [1:0] vo);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = va;
    shamt    = vs;
    op       = vo;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [31:0] va, input logic [4:0] vs,
                       input logic [1:0] vo, input logic [31:0] exp);
    int lat;
    start_req(va, vs, vo);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'd32);
    check(name, result, exp);
    consume();
  endtask

  initial begin
    logic [31:0] snap;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic [1:0]  ro;
    int          lat;

    vecs[0] = '{32'h000000FF, 5'd4,  SHIFT_SLL, 32'h00000FF0};
    vecs[1] = '{32'h80000000, 5'd31, SHIFT_SRA, 32'hFFFFFFFF};
    vecs[2] = '{32'h80000000, 5'd31, SHIFT_SRL, 32'h00000001};
    vecs[3] = '{32'hDEADBEEF, 5'd0,  SHIFT_SLL, 32'hDEADBEEF};
    vecs[4] = '{32'hDEADBEEF, 5'd0,  SHIFT_SRL, 32'hDEADBEEF};
    vecs[5] = '{32'hDEADBEEF, 5'd0,  SHIFT_SRA, 32'hDEADBEEF};
    vecs[6] = '{32'hF0000000, 5'd4,  SHIFT_SRL, 32'h0F000000};
    vecs[7] = '{32'hF0000000, 5'd4,  SHIFT_SRA, 32'hFF000000};
    vecs[8] = '{32'hDEADBEEF, 5'd0,  SHIFT_ROR, 32'hDEADBEEF};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[9] = '{32'h00000001, 5'd1,  SHIFT_ROR, 32'h80000000};
`else
    vecs[9] = '{32'h00000001, 5'd1,  SHIFT_ROR, 32'h00000000};
`endif

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    shamt     = '0;
    op        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_result",    result,         32'd0);

    for (int unsigned i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].s, vecs[i].op, vecs[i].exp);

    // Hold DONE with out_ready low while a new request waits
    start_req(32'h12345678, 5'd8, SHIFT_SLL);
    wait_done(lat);
    check("hold_latency", 32'(lat), 32'd32);
    check("hold_result",  result, 32'h34567800);
    snap = result;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hFFFFFFFF;
    shamt    = 5'd1;
    op       = SHIFT_SRL;
    for (int unsigned c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_stable",    result,         snap);
      check("hold_in_ready",  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("post_hs_in_ready",  32'(in_ready),  32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_busy",      32'(busy),      32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("queued_accept_busy",     32'(busy),     32'd1);
    check("queued_accept_in_ready", 32'(in_ready), 32'd0);
    wait_done(lat);
    check("queued_latency", 32'(lat), 32'd32);
    check("queued_result",  result,   32'h7FFFFFFF);
    consume();

    // Abort mid-BUSY just before bit 10 is written
    start_req(32'hFFFFFFFF, 5'd0, SHIFT_SLL);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("partial_result", result, 32'h000003FF);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result",    result,         32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op("after_abort", 32'h00000001, 5'd31, SHIFT_SLL, 32'h80000000);

    for (int unsigned r = 0; r < 1024; r++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      ro = 2'($urandom_range(0, 3));
      do_op($sformatf("rand%0d", r), ra, rs, ro, model(ra, rs, ro));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Bit-serial shift controller that time-shares one `mux32` to compute a full 32-bit shift, one result bit per cycle. It sits in the ALU shifter path as a low-area alternative to a 32-mux barrel shifter. It accepts an operand, shift amount and op over a valid/ready handshake, sequences the shared mux through all 32 output bits, and returns the result over a second valid/ready handshake.

## Interface
- No parameters; width is fixed at 32 by `mux32` (5-bit select).

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-low.
- `in_valid` input 1: request present.
- `in_ready` output 1: high only in IDLE.
- `a` input 32: operand, captured on accept.
- `shamt` input 5: shift amount 0..31, captured on accept.
- `op` input 2: `shift_op_t` (SLL, SRL, SRA, ROR), captured on accept.
- `out_valid` output 1: result available (DONE state).
- `out_ready` input 1: consumer accepts result.
- `result` output 32: shifted value, held stable while `out_valid`.
- `busy` output 1: high in BUSY.

## Operation
- FSM states:
  - IDLE → BUSY on `in_valid && in_ready`; `a_q`, `shamt_q` and `op_q` are latched, `idx` cleared to 0, `result` cleared to 0.
  - BUSY: each cycle, `result[idx]` is written from the mux path and `idx` increments. After `idx==31` is written, → DONE.
  - DONE: `out_valid=1`. On `out_ready` → IDLE.
- Mux path: `mux32.a = a_q`, `mux32.s = src`. Per op:
  - SLL: `src = idx - shamt_q`. Bit is `y` if `idx >= shamt_q`, else 0.
  - SRL: `src = idx + shamt_q`. Bit is `y` if `idx + shamt_q <= 31` (6-bit compare), else 0.
  - SRA: same as SRL, but the out-of-range fill is `a_q[31]`.
  - ROR: `src = (idx + shamt_q) mod 32`, always `y` (see Configuration).
- `src` is always driven with a defined 5-bit value; out-of-range selects are masked downstream, never left X.
- `shamt=0` yields `result == a` for every op.
- Inputs are ignored outside IDLE; `in_ready=0` in BUSY and DONE.
- Reset values: state IDLE, `in_ready=1` (combinational from state), `out_valid=0`, `busy=0`, `result=0`, `idx=0`.
- Reset mid-BUSY or mid-DONE aborts the operation: outputs return to reset values on the next edge and the pending result is discarded.

## Timing
- Accept at edge T. BUSY spans edges T+1..T+32; bit k is written at edge T+1+k.
- `out_valid` rises after edge T+32, i.e. 32 cycles after accept.
- The result is consumed at the first edge with `out_ready=1` in DONE. `in_ready` rises the following cycle.
- Minimum request-to-request period is 34 cycles. There is no accept in DONE, even if `out_ready` and `in_valid` are both high in the same cycle.
- `result` bits already written are visible during BUSY but are not valid until `out_valid`.

## Configuration
- `SHIFT_SEQ_ROTATE_EN` defined: op ROR (2'b11) performs rotate-right with wrap-around selection.
- `SHIFT_SEQ_ROTATE_EN` undefined: ROR is decoded as SRL (zero fill), and the wrap logic is not compiled.

## Structure
- `shift_pkg` holds:
  - `shift_op_t` enum: SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11.
  - `shift_seq_state_t` (IDLE, BUSY, DONE).
  - constant `SHIFT_W=32`.
- Exactly one sub-module: the existing `mux32` (ports `a`, `s`, `y`), instantiated once.
- Index arithmetic and masking live inline in `shift_sequencer`.

## Test plan
- Release reset; check the reset values. Then SLL `a=0x000000FF`, `shamt=4` → `result=0x00000FF0`, `out_valid` exactly 32 cycles after accept.
- SRA `a=0x80000000`, `shamt=31` → `0xFFFFFFFF`. SRL with the same inputs → `0x00000001`.
- `shamt=0` with `a=0xDEADBEEF` for SLL, SRL and SRA → `0xDEADBEEF` each.
- Hold `out_ready=0` for 10 cycles in DONE: `result` and `out_valid` stay stable and `in_ready=0`. Assert `in_valid` throughout and confirm no accept until one cycle after the handshake.
- Assert `rst` low at BUSY bit 10 → next cycle `out_valid=0`, `result=0`, `in_ready=1`. A following SLL `a=1`, `shamt=31` → `0x80000000`.
- ROR `a=0x00000001`, `shamt=1`:
  - with `SHIFT_SEQ_ROTATE_EN` → `0x80000000`;
  - without it → `0x00000000`.
- Run 1024 random (`a`, `shamt`, `op`) requests against a behavioural model; zero mismatches required.
